// File: rtl/dmem_arb_pkg.sv
// Shared constants for the two-master data-memory arbiter: FSM encoding,
// RV32 load/store size codes and the access legality rule.
package dmem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Unsigned sizes have no store form; halves and words must be naturally aligned.
    function automatic logic access_illegal(input logic we, input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic ill;
        ill = 1'b0;
        case (funct3)
            3'b011, 3'b110, 3'b111: ill = 1'b1;
            3'b100:                 ill = we;
            3'b101:                 ill = we | addr_lo[0];
            3'b010:                 ill = |addr_lo;
            3'b001:                 ill = addr_lo[0];
            default:                ill = 1'b0;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, pointer advances only when a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       arb_en,
    output logic [1:0] grant
);

    // last_m1 = 1 means requester 1 won last, so requester 0 is favoured next.
    logic last_m1;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_m1 ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_m1 <= 1'b1;
        else if (arb_en && |req)
            last_m1 <= grant[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between two requesters with a fixed
// IDLE -> ACCESS -> RESP sequence (ack two cycles after the request is taken).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [2:0]            m0_funct3,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [2:0]            m1_funct3,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef struct packed {
        logic                  we;
        logic [2:0]            funct3;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  id;
    } acc_t;

    logic [1:0]            state;
    logic [1:0]            req;
    logic [1:0]            grant;
    acc_t                  lat;
    logic [DATA_WIDTH-1:0] resp;
    logic                  ill;
    logic                  in_access;
    logic                  in_resp;

    assign req = {m1_req, m0_req};

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .arb_en (state == ST_IDLE),
        .grant  (grant)
    );

    assign ill = access_illegal(lat.we, lat.funct3, lat.addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            lat   <= '0;
            resp  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (|req) begin
                    state <= ST_ACCESS;
                    lat   <= grant[1] ? acc_t'{m1_we, m1_funct3, m1_addr, m1_wdata, 1'b1}
                                      : acc_t'{m0_we, m0_funct3, m0_addr, m0_wdata, 1'b0};
                end
                ST_ACCESS: begin
                    state <= ST_RESP;
                    resp  <= (!lat.we && !ill) ? mem_rd_data : '0;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_access = (state == ST_ACCESS);
    assign in_resp   = (state == ST_RESP);

    // Memory port is quiet outside ACCESS so stale latched values never leak out.
    assign mem_wr_en   = in_access & lat.we & ~ill;
    assign mem_funct3  = in_access ? lat.funct3 : 3'b000;
    assign mem_addr    = in_access ? lat.addr   : '0;
    assign mem_wr_data = in_access ? lat.wdata  : '0;

    assign m0_ack   = in_resp & ~lat.id;
    assign m1_ack   = in_resp &  lat.id;
    assign m0_err   = m0_ack & ill;
    assign m1_err   = m1_ack & ill;
    assign m0_rdata = m0_ack ? resp : '0;
    assign m1_rdata = m1_ack ? resp : '0;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, 32, byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have, per requester n in {0,1}, port mn_req  input  1  access request, held high until mn_ack.
REQ-006 SHALL have, per requester n, port mn_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have, per requester n, port mn_funct3  input  3  RV32 load/store size code.
REQ-008 SHALL have, per requester n, port mn_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have, per requester n, port mn_wdata  input  DATA_WIDTH  store data.
REQ-010 SHALL have, per requester n, port mn_ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have, per requester n, port mn_err  output  1  qualifies mn_ack; illegal or misaligned access.
REQ-012 SHALL have, per requester n, port mn_rdata  output  DATA_WIDTH  load result, valid with mn_ack.
REQ-013 SHALL have port mem_wr_en  output  1  data memory write enable.
REQ-014 SHALL have port mem_funct3  output  3  size code to data memory.
REQ-015 SHALL have port mem_addr  output  ADDR_WIDTH  address to data memory.
REQ-016 SHALL have port mem_wr_data  output  DATA_WIDTH  store data to data memory.
REQ-017 SHALL have port mem_rd_data  input  DATA_WIDTH  combinational read data from data memory.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any mn_req=1, ACCESS->RESP always, RESP->IDLE always.
REQ-019 SHALL arbitrate only in IDLE: single requester wins; if both request, winner is the one not granted last (round-robin pointer), then pointer updates to the winner.
REQ-020 SHALL latch the winner's we, funct3, addr, wdata and winner ID on the IDLE->ACCESS edge; later changes on requester inputs SHALL be ignored until next IDLE.
REQ-021 SHALL classify latched access as illegal when: funct3 in {011,110,111}; store with funct3 in {100,101}; funct3 010 with addr[1:0]!=0; funct3 001/101 with addr[0]!=0.
REQ-022 SHALL, in ACCESS, drive mem_funct3/mem_addr/mem_wr_data from latched values and assert mem_wr_en=1 only for a legal store.
REQ-023 SHALL, in ACCESS, capture mem_rd_data into a response register for legal loads; stores and illegal accesses capture 0.
REQ-024 SHALL, in RESP, pulse ack of the winner only for exactly one cycle with rdata = response register and err = illegal flag; the other requester's ack/err SHALL stay 0.
REQ-025 SHALL give fixed latency: req sampled in IDLE at cycle N, memory access cycle N+1, ack cycle N+2; maximum throughput one access per 3 cycles.
REQ-026 SHALL drive mem_wr_en=0, mem_funct3=0, mem_addr=0, mem_wr_data=0 in IDLE and RESP.
REQ-027 SHALL ignore the acked requester's still-high req during RESP; a req still high in the following IDLE is a new access.
REQ-028 SHALL hold mn_rdata and mn_err at 0 whenever mn_ack=0.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, force state IDLE, pointer to favour m0, latched request and response registers to 0, all acks/errs/rdata to 0, mem_wr_en to 0.
REQ-030 SHALL abandon an in-flight access on reset in ACCESS or RESP: no write in the cycle after reset, no ack ever issued for it.

Structure
REQ-031 SHALL place FSM state encoding and funct3 constants (LB,LH,LW,LBU,LHU,SB,SH,SW) in shared package dmem_arb_pkg.
REQ-032 SHALL implement arbitration in one sub-module rr_arbiter2 (two requests, pointer, one-hot grant); legality check and FSM stay in dmem_arbiter.

Verification
REQ-033 Bench SHALL cover: m0 load LW addr 0x10, memory word 0xDEADBEEF -> m0_ack at N+2, m0_rdata=0xDEADBEEF, m0_err=0, mem_wr_en never high.
REQ-034 Bench SHALL cover: m0 and m1 both req from reset, held -> grants m0, m1, m0, m1; acks at cycles 2, 5, 8, 11 after first req.
REQ-035 Bench SHALL cover: m1 SW addr 0x22 data 0x12345678 -> m1_ack with m1_err=1, mem_wr_en=0 throughout.
REQ-036 Bench SHALL cover: m1 SB addr 0x8 data 0xA5, then m0 LB addr 0x8 -> mem_wr_en=1 for one cycle, m0_rdata=0xFFFFFFA5.
REQ-037 Bench SHALL cover: rst asserted in ACCESS of an m0 SW -> no ack, mem_wr_en=0 in the cycle after reset, next req served with m0 priority.
